// File: rtl/instr_fetch_buf_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_buf_if
//   Instruction memory read bus between the fetch unit and instruction memory.
//   One request per cycle; read data is valid exactly one cycle after the
//   cycle in which imem_req is high.
//
//   Signals
//     imem_req    master -> slave   read request this cycle
//     imem_addr   master -> slave   byte address of the request (ADDR_W)
//     imem_rdata  slave  -> master  read data (32), one cycle after imem_req
//
//   Modports
//     master : fetch unit side
//     slave  : instruction memory side
// -----------------------------------------------------------------------------
interface instr_fetch_buf_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_buf.sv
// -----------------------------------------------------------------------------
// instr_fetch_buf
//   Instruction fetch unit with a prefetch FIFO, sitting directly upstream of
//   the decoder. Owns the PC, issues sequential word reads to instruction
//   memory, buffers the returned words and presents the oldest one to the
//   decoder. A redirect flushes the buffer, squashes any read still in flight
//   and restarts fetch from the new PC.
//
//   Parameters
//     DEPTH     FIFO entries (power of 2, >= 2)
//     ADDR_W    PC / imem byte-address width
//     RESET_PC  PC loaded at reset (word aligned)
//
//   Ports
//     clk             core clock, posedge
//     reset_n         asynchronous active-low reset
//     next_instr      decoder pop request, ignored while instr_valid=0
//     instr           head instruction, 0 when empty
//     instr_valid     FIFO non-empty
//     instr_pc        byte PC of the head instruction, 0 when empty
//     redirect_valid  flush and load redirect_pc (single-cycle pulse)
//     redirect_pc     new PC, bits [1:0] forced to 0
//     imem            instruction memory read bus (master side)
//
//   Build option
//     IFB_PERF_EN  adds fetch_cnt[31:0] (pushes accepted) and
//                  starve_cnt[31:0] (S_RUN cycles with an empty FIFO).
//                  Both reset to 0, wrap, and survive redirects.
//
//   State | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | first cycle after reset, no request
//   RUN   | issuing requests whenever the credit check allows
//   FLUSH | one dead cycle after a redirect, no request
// -----------------------------------------------------------------------------
module instr_fetch_buf #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              next_instr,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    instr_fetch_buf_if.master imem
`ifdef IFB_PERF_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       starve_cnt
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_redirect;
    logic [ADDR_W-1:0] pend_addr;
    logic              data_pending;

    logic [31:0]       fifo_data [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;

    logic              pop_en;
    logic              push_en;
    logic              issue;
    logic [CNT_W:0]    credit_use;

    assign pc_redirect = redirect_pc & ~ADDR_W'(3);

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? fifo_data[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;

    // A redirect wins over both a same-cycle pop and a same-cycle push.
    assign pop_en  = next_instr & instr_valid & ~redirect_valid;
    assign push_en = data_pending & ~redirect_valid;

    always_comb begin
        count_nxt = count;
        if (redirect_valid) begin
            count_nxt = '0;
        end else if (push_en && !pop_en) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop_en && !push_en) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = redirect_valid ? S_FLUSH : S_RUN;
            S_RUN:   state_nxt = redirect_valid ? S_FLUSH : S_RUN;
            S_FLUSH: state_nxt = redirect_valid ? S_FLUSH : S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Entries held after this edge plus the read whose data lands next cycle.
    // Issuing only while that total is below DEPTH reserves a slot for every
    // outstanding read, so a push can never hit a full FIFO.
    assign credit_use = {1'b0, count_nxt}
                      + (CNT_W+1)'(imem.imem_req & ~redirect_valid);
    assign issue      = (state_nxt == S_RUN) && (credit_use < (CNT_W+1)'(DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            imem.imem_req <= 1'b0;
            imem.imem_addr <= '0;
            data_pending  <= 1'b0;
            pend_addr     <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            // A redirect in the request cycle kills the return in the next one.
            data_pending <= imem.imem_req & ~redirect_valid;
            pend_addr    <= imem.imem_addr;
            imem.imem_req <= issue;
            if (issue) begin
                imem.imem_addr <= pc;
            end

            if (redirect_valid) begin
                pc <= pc_redirect;
            end else if (issue) begin
                pc <= pc + ADDR_W'(4);
            end

            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push_en) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop_en) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_data[wr_ptr] <= imem.imem_rdata;
            fifo_pc[wr_ptr]   <= pend_addr;
        end
    end

    no_push_when_full: assert property (
        @(posedge clk) disable iff (!reset_n)
        !(push_en && (count == CNT_W'(DEPTH)))
    );

`ifdef IFB_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt  <= 32'h0;
            starve_cnt <= 32'h0;
        end else begin
            if (push_en) begin
                fetch_cnt <= fetch_cnt + 32'h1;
            end
            if ((state == S_RUN) && !instr_valid) begin
                starve_cnt <= starve_cnt + 32'h1;
            end
        end
    end
`endif

endmodule
